// File: rtl/debug_trace_unit_if.sv
// Debug trace port bundle: config write, SNN taps, sample/readout strobes
// and the debug output, trace_done and trace_count results.
interface debug_trace_unit_if #(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     en;
  logic [7:0]               debug_config_in;
  logic [NUM_CH*DATA_W-1:0] membrane_potentials;
  logic [DATA_W-1:0]        output_spikes_layer1;
  logic                     sample_valid;
  logic                     rd_en;
  logic [DATA_W-1:0]        debug_select;
  logic                     trace_done;
  logic [CW-1:0]            trace_count;

  modport master (
    output en, debug_config_in, membrane_potentials,
    output output_spikes_layer1, sample_valid, rd_en,
    input  debug_select, trace_done, trace_count
  );

  modport slave (
    input  en, debug_config_in, membrane_potentials,
    input  output_spikes_layer1, sample_valid, rd_en,
    output debug_select, trace_done, trace_count
  );
endinterface

// File: rtl/debug_trace_unit.sv
// SNN debug observer: live/freeze source mux plus a triggered trace buffer.
// Ports: clk, rst (async high), dbg (slave modport of debug_trace_unit_if).
module debug_trace_unit #(
  parameter int NUM_CH = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  debug_trace_unit_if.slave dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, ARMED, CAPTURE, DONE
  } state_t;

  typedef enum logic [1:0] {
    M_LIVE   = 2'b00,
    M_FREEZE = 2'b01,
    M_TRIG   = 2'b10,
    M_IMM    = 2'b11
  } mode_t;

  state_t            state_q, state_d;
  logic [7:0]        cfg_q, cfg_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dsel_q, dsel_d;

  logic [DATA_W-1:0] trace_mem [DEPTH];
  logic [DATA_W-1:0] mux;
  logic [DATA_W-1:0] mem_rd;
  logic [AW-1:0]     rd_addr;
  logic              we;
  mode_t             mode;
  logic [5:0]        idx;

  assign idx  = cfg_q[5:0];
  assign mode = mode_t'(cfg_q[7:6]);

  // Indices past the last channel select the spike vector.
  always_comb begin
    mux = dbg.output_spikes_layer1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == 6'(i)) begin
        mux = dbg.membrane_potentials[i*DATA_W +: DATA_W];
      end
    end
  end

  // Single read port: buf[0] on DONE entry, buf[rd+1] while reading out.
  assign rd_addr = (state_q == DONE) ? rd_q + 1'b1 : '0;
  assign mem_rd  = trace_mem[rd_addr];

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    dsel_d  = dsel_q;
    we      = 1'b0;

    if (state_q == DONE) begin
      if (dbg.rd_en && !dbg.en) begin
        rd_d   = rd_q + 1'b1;
        dsel_d = mem_rd;
      end
    end else if (mode != M_FREEZE) begin
      dsel_d = mux;
    end

    // A config write always wins over a same-cycle sample.
    if (dbg.en) begin
      cfg_d = dbg.debug_config_in;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      unique case (dbg.debug_config_in[7:6])
        M_TRIG:  state_d = ARMED;
        M_IMM:   state_d = CAPTURE;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        ARMED: begin
          if (dbg.sample_valid && |dbg.output_spikes_layer1) begin
            we      = 1'b1;
            wr_d    = wr_q + 1'b1;
            cnt_d   = CW'(1);
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (dbg.sample_valid) begin
            we    = 1'b1;
            wr_d  = wr_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DEPTH - 1)) begin
              state_d = DONE;
              rd_d    = '0;
              dsel_d  = mem_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dsel_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      dsel_q  <= dsel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      trace_mem[wr_q] <= mux;
    end
  end

  assign dbg.debug_select = dsel_q;
  assign dbg.trace_done   = (state_q == DONE);
  assign dbg.trace_count  = cnt_q;
endmodule

// File: doc/debug_trace_unit.md
Name: debug_trace_unit

Overview:
- Parametrised debug observation block for the SNN core.
- Selects one of NUM_CH membrane-potential channels, or the layer-1 spike vector, onto a registered debug output.
- Adds freeze and triggered trace capture into an internal DEPTH-entry buffer, read back through the same output pins, so the debug port can show per-timestep history, not just live values.

Parameters:
- NUM_CH, 10, number of membrane-potential channels (1..63).
- DATA_W, 8, width of each channel, of the spike vector and of the debug output.
- DEPTH, 16, trace buffer entries (power of 2, >=2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  config write enable.
- debug_config_in  input  8  [5:0] source index, [7:6] mode.
- membrane_potentials  input  NUM_CH*DATA_W  flattened; channel i = bits [i*DATA_W +: DATA_W].
- output_spikes_layer1  input  DATA_W  layer-1 spike vector.
- sample_valid  input  1  one-cycle strobe per SNN timestep.
- rd_en  input  1  advance trace readout pointer.
- debug_select  output  DATA_W  registered debug output.
- trace_done  output  1  buffer full, readout active.
- trace_count  output  $clog2(DEPTH)+1  entries captured.

Behaviour:
- Reset state: config=0, state IDLE, all pointers 0, debug_select=0, trace_done=0, trace_count=0.
- Config register: loads debug_config_in on en. Any config write returns the trace FSM to its mode's entry state: pointers and count cleared, trace_done=0. Buffer contents are not cleared.
- Source mux (combinational, from the config register):
  - index < NUM_CH: channel[index].
  - index >= NUM_CH: output_spikes_layer1.
- Mode 00 LIVE:
  - debug_select <= mux every cycle.
  - Latency: en at edge N, new source visible after edge N+1.
- Mode 01 FREEZE: debug_select holds its current value and does not update. Leaving FREEZE (config write) resumes normal update.
- Mode 10 TRIGGERED. FSM IDLE -> ARMED on config write.
  - ARMED: on sample_valid && |output_spikes_layer1, write mux to buf[0], go to CAPTURE, count=1.
  - debug_select stays live in ARMED and CAPTURE.
- Mode 11 IMMEDIATE: FSM enters CAPTURE on config write with count=0. The first write happens on the next sample_valid.
- CAPTURE:
  - Each sample_valid writes mux to buf[wr_ptr], then wr_ptr++ and count++.
  - When count reaches DEPTH: go to DONE, trace_done=1, writes stop, further sample_valid ignored.
  - sample_valid on the same cycle as en: the config write wins and no sample is written.
- DONE:
  - On entry, debug_select <= buf[0], rd_ptr=0.
  - rd_en: rd_ptr <= rd_ptr+1 (mod DEPTH) and debug_select <= buf[rd_ptr+1]. One-cycle latency; wraps DEPTH-1 -> 0.
  - Stays in DONE until a config write.
- rd_en outside DONE is ignored.
- trace_count saturates at DEPTH.
- Reset mid-capture aborts immediately to the reset state.
- Buffer: DEPTH x DATA_W, single write port, single read port, no reset required on the array.

Test Plan:
- LIVE: write config 0x03, channel 3 = 0x5A -> debug_select=0x5A two cycles after en. Write 0x3F -> spikes 0xC3 shown.
- FREEZE: LIVE on ch0 = 0x11, write 0x40, change ch0 to 0x22 -> debug_select stays 0x11. Write 0x00 -> 0x22.
- TRIGGERED: write 0x81 (ch1), pulse sample_valid with spikes=0 x3 -> count stays 0.
  - Then spikes=0x01 with ch1=k, for k=0..15 on successive samples -> trace_done=1, count=16, debug_select=0.
  - 15 rd_en pulses -> 1..15; 16th -> wraps to 0.
- IMMEDIATE: write 0xC0, 16 sample_valid with ch0=0xA0+k -> trace_done after the 16th. A 17th sample_valid does not change buf.
- Abort: mid-capture (count=5) write 0xC0 -> count=0, trace_done=0. Async rst mid-capture -> all outputs 0 without a clock edge.
- Collision: en and sample_valid on the same cycle in CAPTURE -> no write, count=0 afterwards.
